div32_seq: RTL and testbench

// - Iterative restoring divider for the CPU32 execute stage; the inverse of the add/multiply datapath.
// - Accepts one signed or unsigned divide on a start pulse and produces quotient and remainder.
// - Retires one quotient bit per cycle using a carry-lookahead subtract stage.
// - Raises a one-cycle done pulse and holds the results until the next start.

---
 rtl/div_pkg.sv | 24 ++
 rtl/sub_cla.sv | 49 ++++
 rtl/div32_seq.sv | 150 +++++++++++++++
 tb/tb_div32_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the
// counter-width helper used to size the bit counter.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sub_cla.sv
// WIDTH-bit subtractor a - b computed as a + ~b + 1 with 4-bit carry-lookahead
// groups rippling group-to-group; cout high means no borrow.
module sub_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             cout_o
);

  localparam int NGRP = (WIDTH + 3) / 4;
  localparam int WPAD = NGRP * 4;

  logic [WPAD-1:0] g;
  logic [WPAD-1:0] p;
  logic [WPAD-1:0] d;
  logic [WPAD:0]   c;

  // NOTE: every variable assigned in this block gets a value on every pass
  // before it is read, so no latch is inferred.
  always_comb begin
    g    = WPAD'(a_i) & WPAD'(~b_i);
    p    = WPAD'(a_i) ^ WPAD'(~b_i);
    c    = '0;
    c[0] = 1'b1;
    for (int k = 0; k < NGRP; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
    d = p ^ c[WPAD-1:0];
  end

  assign diff_o = d[WIDTH-1:0];
  assign cout_o = c[WIDTH];

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with sign fix-up and divide-by-zero handling in a final FIX cycle.
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = clog2(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             dz_q;
  logic             done_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] quot_out_q;
  logic [WIDTH-1:0] rem_out_q;

  logic [WIDTH-1:0] main_a;
  logic [WIDTH-1:0] main_b;
  logic [WIDTH-1:0] main_diff;
  logic             main_cout;
  logic [WIDTH-1:0] aux_b;
  logic [WIDTH-1:0] aux_diff;
  logic             aux_cout;
  logic [WIDTH-1:0] shifted;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  // Main subtractor: negates the dividend in IDLE, forms the trial difference
  // in CALC and negates the quotient in FIX.
  always_comb begin
    main_a = '0;
    main_b = dividend;
    case (state_q)
      CALC: begin
        main_a = shifted;
        main_b = dvs_q;
      end
      FIX:     main_b = dvd_q;
      default: ;
    endcase
  end

  // Aux subtractor computes 0 - b: negates the divisor in IDLE (its carry-out
  // is set exactly when the divisor is zero) and the remainder in FIX.
  assign aux_b = (state_q == IDLE) ? divisor : rem_q;

  sub_cla #(.WIDTH(WIDTH)) u_sub_main (
    .a_i    (main_a),
    .b_i    (main_b),
    .diff_o (main_diff),
    .cout_o (main_cout)
  );

  sub_cla #(.WIDTH(WIDTH)) u_sub_aux (
    .a_i    ('0),
    .b_i    (aux_b),
    .diff_o (aux_diff),
    .cout_o (aux_cout)
  );

  assign shifted = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  // The remainder MSB shifted out means the true trial value is >= 2^WIDTH,
  // which always exceeds the divisor, so the subtraction must succeed.
  assign q_bit   = main_cout | rem_q[WIDTH-1];
  assign dvd_abs = (is_signed & dividend[WIDTH-1]) ? main_diff : dividend;
  assign dvs_abs = (is_signed & divisor[WIDTH-1])  ? aux_diff  : divisor;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dz_q       <= aux_cout;
            dvd_q      <= aux_cout ? dividend : dvd_abs;
            dvs_q      <= dvs_abs;
            rem_q      <= '0;
            neg_quot_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q  <= is_signed & dividend[WIDTH-1];
            cnt_q      <= CW'(WIDTH - 1);
            state_q    <= aux_cout ? FIX : CALC;
          end
        end
        CALC: begin
          rem_q <= q_bit ? main_diff : shifted;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (dz_q) begin
            quot_out_q <= '1;
            rem_out_q  <= dvd_q;
          end else begin
            quot_out_q <= neg_quot_q ? main_diff : dvd_q;
            rem_out_q  <= neg_rem_q  ? aux_diff  : rem_q;
          end
          div_zero_q <= dz_q;
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quot_out_q;
  assign remainder = rem_out_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed corner cases plus random operands,
// expectations queued at issue and checked by a monitor on each done pulse.
module tb_div32_seq;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_cmp    = 0;
  int           n_mis    = 0;
  int           cyc      = 0;
  int           busy_run = 0;
  logic [W-1:0] last_q   = '0;
  logic [W-1:0] last_r   = '0;
  logic         last_dz  = 1'b0;

  div32_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands, with the two cases the
  // language operators leave undefined handled explicitly.
  function automatic exp_t ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sv;
    e.acc = 0;
    e.lat = LAT;
    e.dz  = 1'b0;
    sa    = a;
    sv    = b;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 1;
    end else if (s && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      e.q = a;
      e.r = '0;
    end else if (s) begin
      e.q = sa / sv;
      e.r = sa % sv;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Monitor: compares every done pulse with the oldest queued expectation and
  // checks that results stay frozen between done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_q   = '0;
      last_r   = '0;
      last_dz  = 1'b0;
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        check("busy_low_at_done", 32'(busy), '0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), '0);
        end else begin
          mon_e = sb.pop_front();
          check("quotient", quotient, mon_e.q);
          check("remainder", remainder, mon_e.r);
          check("div_zero", 32'(div_zero), 32'(mon_e.dz));
          check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          check("busy_cycles", 32'(busy_run), 32'(mon_e.lat));
        end
        last_q   = quotient;
        last_r   = remainder;
        last_dz  = div_zero;
        busy_run = 0;
      end else begin
        check("hold_quotient", quotient, last_q);
        check("hold_remainder", remainder, last_r);
        check("hold_div_zero", 32'(div_zero), 32'(last_dz));
      end
    end
  end

  // Waits for the divider to go idle (the done cycle at the earliest), then
  // presents one request for exactly one cycle.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int   n;
    exp_t e;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_before_issue", 32'(busy), '0);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.acc = cyc + 1;
    e.lat = edz ? 1 : LAT;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue_model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = ref_div(s, a, b);
    issue(s, a, b, e.q, e.r, e.dz);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), '0);
    check({tag, "_done"}, 32'(done), '0);
    check({tag, "_quotient"}, quotient, '0);
    check({tag, "_remainder"}, remainder, '0);
    check({tag, "_div_zero"}, 32'(div_zero), '0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           mode;
    int           n;

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    issue(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
    issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
    issue(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    issue(1'b1, 32'h8000_0001, 32'd0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0);

    // A start pulse while busy must not disturb the running divide or queue.
    issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid_op", 32'(busy), 32'd1);
    is_signed = 1'b0;
    dividend  = 32'd7;
    divisor   = 32'd0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Reset about ten cycles into an op: no done may follow it.
    issue(1'b0, 32'd1_000_000, 32'd3, 32'd333_333, 32'd1, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_state("midop_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_reset", 32'(busy), '0);
    issue(1'b0, 32'd5, 32'd5, 32'd1, 32'd0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      s    = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0: b = '0;
        1: begin
          b = $urandom_range(1, 15);
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        2: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        3: a = $urandom_range(0, 1000);
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      issue_model(s, a, b);
    end

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), '0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
